// File: rtl/perf_counter_reader_if.sv
// Snapshot port from the perf counter reader to the CSR block: valid/ready with a wide total.
// The reader side drives valid and data; the CSR side drives ready.
interface perf_counter_reader_if #(
    parameter int ACC_WIDTH = 16
);
    logic                 rd_valid;
    logic                 rd_ready;
    logic [ACC_WIDTH-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/perf_counter_reader.sv
// Purpose: pulses sw_req_o periodically (or on demand) and folds the returned count into a running total.
// Latency: the total appears on rd one cycle after the sw_req_o cycle. PERF_RD_SATURATE_EN selects saturate over wrap.
// Backpressure: none on sampling; an unaccepted snapshot is overwritten by the next one (latest wins).
module perf_counter_reader #(
    parameter int CNT_WIDTH = 4,
    parameter int ACC_WIDTH = 16,
    parameter int PERIOD    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  sample_now_i,
    input  logic                  clear_i,
    output logic                  sw_req_o,
    input  logic [CNT_WIDTH-1:0]  p_count_i,
    perf_counter_reader_if.master rd,
    output logic                  overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(PERIOD - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sw_req_q, sw_req_d;
    logic [ACC_WIDTH-1:0] total_q, total_d;
    logic [ACC_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 overflow_q, overflow_d;

    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] total_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_now_i) begin
                    state_d = ST_REQ;
                end else if (en_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = RELOAD;
                end
            end
            ST_WAIT: begin
                if (sample_now_i) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end else if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_WIDTH'(1)) begin
                    // The decremented count reaching zero fires the request.
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_REQ: begin
                if (en_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = RELOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        sw_req_d = (state_d == ST_REQ);
    end

    always_comb begin
        // A clear in the request cycle restarts the total from this sample.
        base = clear_i ? '0 : total_q;
        sum  = {1'b0, base} + {{(ACC_WIDTH + 1 - CNT_WIDTH){1'b0}}, p_count_i};
`ifdef PERF_RD_SATURATE_EN
        total_nxt = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
        total_nxt = sum[ACC_WIDTH-1:0];
`endif
        total_d    = sw_req_q ? total_nxt : base;
        overflow_d = (clear_i ? 1'b0 : overflow_q) | (sw_req_q & sum[ACC_WIDTH]);
        rd_valid_d = sw_req_q | (rd_valid_q & ~rd.rd_ready);
        rd_data_d  = sw_req_q ? total_nxt : rd_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sw_req_q   <= 1'b0;
            total_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sw_req_q   <= sw_req_d;
            total_q    <= total_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign sw_req_o    = sw_req_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = rd_data_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed bench for perf_counter_reader: a 16-bit instance driven by a small trigger-counter model,
// and a 5-bit-total instance driven directly to reach the overflow boundary.
module tb_perf_counter_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en, sample_now, clear, trig;
    logic       sw_req, ovf;
    logic [3:0] p_count;

    logic       en2, sample_now2, clear2, sw_req2, ovf2;
    logic [3:0] p_count2;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    perf_counter_reader_if #(.ACC_WIDTH(16)) rd_if ();
    perf_counter_reader_if #(.ACC_WIDTH(5))  rd_if2 ();

    perf_counter_reader #(.CNT_WIDTH(4), .ACC_WIDTH(16), .PERIOD(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .en_i         (en),
        .sample_now_i (sample_now),
        .clear_i      (clear),
        .sw_req_o     (sw_req),
        .p_count_i    (p_count),
        .rd           (rd_if),
        .overflow_o   (ovf)
    );

    perf_counter_reader #(.CNT_WIDTH(4), .ACC_WIDTH(5), .PERIOD(8)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .en_i         (en2),
        .sample_now_i (sample_now2),
        .clear_i      (clear2),
        .sw_req_o     (sw_req2),
        .p_count_i    (p_count2),
        .rd           (rd_if2),
        .overflow_o   (ovf2)
    );

    // Event counter: returns its count while sw_req is high, then restarts from
    // whatever trigger arrives in that same cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset)      p_count <= 4'd0;
        else if (sw_req) p_count <= {3'b000, trig};
        else             p_count <= p_count + {3'b000, trig};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sw_req === 1'b1) pulses++;
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; sample_now = 1'b0; clear = 1'b0; trig = 1'b0;
        rd_if.rd_ready = 1'b0;
        en2 = 1'b0; sample_now2 = 1'b0; clear2 = 1'b0; p_count2 = 4'd0;
        rd_if2.rd_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_sw_req",   32'(sw_req),         0);
        check("rst_rd_valid", 32'(rd_if.rd_valid), 0);
        check("rst_rd_data",  32'(rd_if.rd_data),  0);
        check("rst_overflow", 32'(ovf),            0);

        // 1: en rises at c0, five triggers, single pulse at c8, total 5 at c9
        reset = 1'b1;
        en = 1'b1; trig = 1'b1; pulses = 0;
        step(5);
        trig = 1'b0;
        step(3);
        check("t1_pulse_count", 32'(pulses),  1);
        check("t1_sw_req_c8",   32'(sw_req),  1);
        check("t1_p_count",     32'(p_count), 5);
        step(1);
        check("t1_sw_req_c9",   32'(sw_req),         0);
        check("t1_rd_valid",    32'(rd_if.rd_valid), 1);
        check("t1_rd_data",     32'(rd_if.rd_data),  5);

        // 2: clear keeps the snapshot; with ready low, 3 then 4 -> 3 then 7
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t2_clr_valid", 32'(rd_if.rd_valid), 1);
        check("t2_clr_data",  32'(rd_if.rd_data),  5);
        check("t2_clr_ovf",   32'(ovf),            0);
        trig = 1'b1; pulses = 0;
        step(3);
        trig = 1'b0;
        step(3);
        check("t2_req1",      32'(sw_req),  1);
        check("t2_cnt1",      32'(p_count), 3);
        step(1);
        check("t2_valid1",    32'(rd_if.rd_valid), 1);
        check("t2_data1",     32'(rd_if.rd_data),  3);
        trig = 1'b1;
        step(4);
        trig = 1'b0;
        step(3);
        check("t2_req2",      32'(sw_req),  1);
        check("t2_cnt2",      32'(p_count), 4);
        rd_if.rd_ready = 1'b1;
        step(1);
        check("t2_valid_same_cycle", 32'(rd_if.rd_valid), 1);
        check("t2_data2",            32'(rd_if.rd_data),  7);
        check("t2_pulses",           32'(pulses),         2);
        step(1);
        rd_if.rd_ready = 1'b0;
        check("t2_accept_clears", 32'(rd_if.rd_valid), 0);
        check("t2_data_held",     32'(rd_if.rd_data),  7);

        // 3: build total 9, then clear in a REQ cycle with p_count 2
        trig = 1'b1;
        step(2);
        trig = 1'b0; sample_now = 1'b1;
        step(1);
        sample_now = 1'b0;
        check("t3_now_req", 32'(sw_req),  1);
        check("t3_cnt_a",   32'(p_count), 2);
        step(1);
        check("t3_total9",  32'(rd_if.rd_data), 9);
        trig = 1'b1;
        step(2);
        trig = 1'b0; sample_now = 1'b1;
        step(1);
        check("t3_req_b",   32'(sw_req),  1);
        check("t3_cnt_b",   32'(p_count), 2);
        clear = 1'b1;
        step(1);
        clear = 1'b0; sample_now = 1'b0;
        check("t3_now_ignored_in_req", 32'(sw_req),         0);
        check("t3_clr_req_data",       32'(rd_if.rd_data),  2);
        check("t3_clr_req_valid",      32'(rd_if.rd_valid), 1);
        check("t3_clr_req_ovf",        32'(ovf),            0);

        // 5: async reset in REQ, restart needs en plus a full period, then reset in WAIT
        step(7);
        check("t5_in_req", 32'(sw_req), 1);
        reset = 1'b0;
        #1;
        check("t5_req_rst_sw_req",   32'(sw_req),         0);
        check("t5_req_rst_rd_valid", 32'(rd_if.rd_valid), 0);
        check("t5_req_rst_rd_data",  32'(rd_if.rd_data),  0);
        en = 1'b0;
        step(2);
        reset = 1'b1; pulses = 0;
        step(3);
        check("t5_idle_no_pulse", 32'(pulses), 0);
        en = 1'b1;
        step(7);
        check("t5_no_early_pulse", 32'(pulses), 0);
        step(1);
        check("t5_full_period",    32'(sw_req), 1);
        step(2);
        check("t5_wait_valid_pre", 32'(rd_if.rd_valid), 1);
        reset = 1'b0;
        #1;
        check("t5_wait_rst_sw_req",   32'(sw_req),         0);
        check("t5_wait_rst_rd_valid", 32'(rd_if.rd_valid), 0);
        check("t5_wait_rst_rd_data",  32'(rd_if.rd_data),  0);
        en = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);

        // 6: drop en at count 3, re-raise two cycles later; then sample_now from IDLE
        en = 1'b1;
        step(5);
        en = 1'b0;
        step(2);
        en = 1'b1; pulses = 0;
        step(7);
        check("t6_no_pulse_after_reraise", 32'(pulses), 0);
        step(1);
        check("t6_pulse_full_period", 32'(sw_req), 1);
        en = 1'b0;
        step(1);
        sample_now = 1'b1; pulses = 0;
        step(1);
        sample_now = 1'b0;
        check("t6_now_pulse", 32'(sw_req), 1);
        step(4);
        check("t6_now_single", 32'(pulses), 1);
        check("t6_now_idle",   32'(sw_req), 0);

        // 4: 5-bit total, 15 + 15 + 4 crosses 31
        p_count2 = 4'd15; sample_now2 = 1'b1;
        step(1);
        sample_now2 = 1'b0;
        check("t4_req", 32'(sw_req2), 1);
        step(1);
        check("t4_total15", 32'(rd_if2.rd_data), 15);
        sample_now2 = 1'b1;
        step(1);
        sample_now2 = 1'b0;
        step(1);
        check("t4_total30",  32'(rd_if2.rd_data), 30);
        check("t4_ovf_pre",  32'(ovf2),           0);
        p_count2 = 4'd4; sample_now2 = 1'b1;
        step(1);
        sample_now2 = 1'b0;
        step(1);
`ifdef PERF_RD_SATURATE_EN
        check("t4_total_over", 32'(rd_if2.rd_data), 31);
`else
        check("t4_total_over", 32'(rd_if2.rd_data), 2);
`endif
        check("t4_ovf_set", 32'(ovf2), 1);
        p_count2 = 4'd0; sample_now2 = 1'b1;
        step(1);
        sample_now2 = 1'b0;
        step(1);
        check("t4_ovf_sticky", 32'(ovf2), 1);
        clear2 = 1'b1;
        step(1);
        clear2 = 1'b0;
        check("t4_ovf_cleared", 32'(ovf2), 0);
`ifdef PERF_RD_SATURATE_EN
        check("t4_data_after_clear", 32'(rd_if2.rd_data), 31);
`else
        check("t4_data_after_clear", 32'(rd_if2.rd_data), 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
